// File: rtl/colour_game_pkg.sv
// Shared types and constants for the colour sequence game: FSM state encoding,
// RGB565 palette for the downstream pixel mux, and a one-hot colour helper.
package colour_game_pkg;

    typedef enum logic [3:0] {
        IDLE,
        APPEND,
        SHOW_ON,
        SHOW_OFF,
        INPUT,
        RELEASE,
        PAUSE,
        GAMEOVER,
        WIN,
        WAITREL
    } game_state_t;

    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_GREEN  = 16'h5FE8;
    localparam logic [15:0] RGB_RED    = 16'hFA28;
    localparam logic [15:0] RGB_BLUE   = 16'h12DE;
    localparam logic [15:0] RGB_YELLOW = 16'hFFC6;

    function automatic logic [7:0] onehot8(input logic [2:0] code);
        return 8'b1 << code;
    endfunction

endpackage

// File: rtl/game_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every clock cycle;
// SEED must be non-zero or the register locks up at zero.
module game_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    assign value_d = {value_q[14:0], value_q[15] ^ value_q[13] ^ value_q[12] ^ value_q[10]};
    assign value   = value_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/colour_sequence_game.sv
// Simon-style sequence game: grows a random colour sequence, replays it one-hot,
// then scores key presses. Optional input timeout via COLOUR_GAME_TIMEOUT_EN.
module colour_sequence_game
    import colour_game_pkg::*;
#(
    parameter int          NUM_KEYS       = 4,
    parameter int          MAX_SEQ_LEN    = 16,
    parameter int          SHOW_CLOCKS    = 12500000,
    parameter int          GAP_CLOCKS     = 2500000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          TIMEOUT_CLOCKS = 150000000
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_KEYS-1:0]                key,
    output logic [NUM_KEYS-1:0]                colour,
    output logic [$clog2(MAX_SEQ_LEN+1)-1:0]   level,
    output logic                               game_over,
    output logic                               game_won,
    output logic                               input_phase
);

    localparam int CW    = $clog2(NUM_KEYS);
    localparam int LW    = $clog2(MAX_SEQ_LEN + 1);
    localparam int IW    = $clog2(MAX_SEQ_LEN);
    localparam int TMAX1 = (SHOW_CLOCKS > GAP_CLOCKS) ? SHOW_CLOCKS : GAP_CLOCKS;
    localparam int TMAX  = (TMAX1 > TIMEOUT_CLOCKS) ? TMAX1 : TIMEOUT_CLOCKS;
    localparam int TW    = $clog2(TMAX + 1);

    game_state_t         state_q, state_d;
    logic [LW-1:0]       level_q, level_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_KEYS-1:0] echo_q, echo_d;
    logic                correct_q, correct_d;

    logic [CW-1:0]       seq_mem [MAX_SEQ_LEN];
    logic [CW-1:0]       seq_rd;
    logic [CW-1:0]       element;
    logic                seq_we;
    logic [15:0]         lfsr_value;
    logic [NUM_KEYS-1:0] exp_colour;
    logic                key_any;
    logic                key_match;
    logic                timer_zero;
    logic                idx_last;

    game_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_value)
    );

    // Only the low byte feeds the colour pick; the rest is pure LFSR state.
    logic [7:0] lfsr_unused;
    assign lfsr_unused = lfsr_value[15:8];

    assign element    = CW'(lfsr_value[7:0] % 8'(NUM_KEYS));
    assign seq_rd     = seq_mem[idx_q];
    assign exp_colour = NUM_KEYS'(onehot8(3'(seq_rd)));
    assign key_any    = |key;
    assign key_match  = (key == exp_colour);
    assign timer_zero = (timer_q == '0);
    assign idx_last   = (LW'(idx_q) == level_q - 1'b1);

    // Sequence memory is never cleared; level gates which entries are valid.
    always_ff @(posedge clock) begin
        if (seq_we) begin
            seq_mem[IW'(level_q)] <= element;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            level_q   <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            echo_q    <= '0;
            correct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            echo_q    <= echo_d;
            correct_q <= correct_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        idx_d     = idx_q;
        echo_d    = echo_q;
        correct_d = correct_q;
        seq_we    = 1'b0;

        case (state_q)
            IDLE, GAMEOVER, WIN: begin
                if (key_any) begin
                    state_d = WAITREL;
                    level_d = '0;
                end
            end
            WAITREL: begin
                if (!key_any) state_d = APPEND;
            end
            APPEND: begin
                seq_we  = 1'b1;
                level_d = level_q + 1'b1;
                idx_d   = '0;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                if (timer_zero) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (timer_zero) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = INPUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SHOW_ON;
                    end
                end
            end
            INPUT: begin
                // Only the first non-zero sample is scored; later changes are ignored.
                if (key_any) begin
                    echo_d    = key;
                    correct_d = key_match;
                    state_d   = RELEASE;
                end
`ifdef COLOUR_GAME_TIMEOUT_EN
                else if (timer_zero) begin
                    state_d = GAMEOVER;
                end
`endif
            end
            RELEASE: begin
                if (!key_any) begin
                    if (!correct_q) begin
                        state_d = GAMEOVER;
                    end else if (!idx_last) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = INPUT;
                    end else if (level_q == LW'(MAX_SEQ_LEN)) begin
                        state_d = WIN;
                    end else begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (timer_zero) state_d = APPEND;
            end
            default: state_d = IDLE;
        endcase

        // Timer reloads whenever a new state is entered, otherwise counts to zero.
        timer_d = timer_zero ? '0 : timer_q - 1'b1;
        if (state_d != state_q) begin
            case (state_d)
                SHOW_ON:         timer_d = TW'(SHOW_CLOCKS - 1);
                SHOW_OFF, PAUSE: timer_d = TW'(GAP_CLOCKS - 1);
`ifdef COLOUR_GAME_TIMEOUT_EN
                INPUT:           timer_d = TW'(TIMEOUT_CLOCKS);
`endif
                default:         timer_d = '0;
            endcase
        end
    end

    always_comb begin
        colour = '0;
        case (state_q)
            SHOW_ON: colour = exp_colour;
            RELEASE: colour = echo_q;
            default: colour = '0;
        endcase
    end

    assign level       = level_q;
    assign game_over   = (state_q == GAMEOVER);
    assign game_won    = (state_q == WIN);
    assign input_phase = (state_q == INPUT) || (state_q == RELEASE);

endmodule

// File: tb/tb_colour_sequence_game.sv
// Randomised self-checking bench for colour_sequence_game; the expected colour
// sequence is derived from the LFSR rule and the cycle count since reset.
module tb_colour_sequence_game;
    import colour_game_pkg::*;

    localparam int NK   = 4;
    localparam int MAXL = 3;
    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '0;
    logic [NK-1:0] colour;
    logic [1:0]    level;
    logic          game_over;
    logic          game_won;
    logic          input_phase;

    int total = 0;
    int bad   = 0;
    int cyc;
    int rel_cyc;
    int append_cyc;
    int model[$];

    colour_sequence_game #(
        .NUM_KEYS       (NK),
        .MAX_SEQ_LEN    (MAXL),
        .SHOW_CLOCKS    (SHOW),
        .GAP_CLOCKS     (GAP),
        .LFSR_SEED      (16'hACE1),
        .TIMEOUT_CLOCKS (TMO)
    ) dut (
        .clock       (clk),
        .reset       (rst),
        .key         (key),
        .colour      (colour),
        .level       (level),
        .game_over   (game_over),
        .game_won    (game_won),
        .input_phase (input_phase)
    );

    always #5 clk = ~clk;

    // Number of rising edges since reset was released = number of LFSR shifts.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int elem_at(input int n);
        logic [15:0] v;
        logic [7:0]  lo;
        v = 16'hACE1;
        for (int i = 0; i < n; i++) v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        lo = v[7:0];
        return int'(lo) % NK;
    endfunction

    // Records the replay as runs of (colour, length, following gap) until input_phase.
    task automatic watch_replay(input int lvl);
        logic [NK-1:0] vals[$];
        int            lens[$];
        int            gaps[$];
        logic [NK-1:0] cur;
        logic [NK-1:0] e;
        int            len;
        int            zeros;
        bit            reached;
        cur = '0; len = 0; zeros = 0; reached = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (input_phase) begin
                reached = 1;
                break;
            end
            if (colour != '0) begin
                if (len > 0 && colour == cur && zeros == 0) begin
                    len++;
                end else begin
                    if (len > 0) begin
                        vals.push_back(cur); lens.push_back(len); gaps.push_back(zeros);
                    end
                    cur = colour; len = 1; zeros = 0;
                end
            end else if (len > 0) begin
                zeros++;
            end
        end
        if (len > 0) begin
            vals.push_back(cur); lens.push_back(len); gaps.push_back(zeros);
        end
        check("replay_reaches_input", 32'(reached), 32'd1);
        check("replay_steps", 32'(vals.size()), 32'(lvl));
        check("replay_level", 32'(level), 32'(lvl));
        for (int i = 0; i < lvl && i < vals.size(); i++) begin
            e = NK'(1) << model[i];
            check("replay_colour", 32'(vals[i]), 32'(e));
            check("replay_show_len", 32'(lens[i]), 32'(SHOW));
            check("replay_gap_len", 32'(gaps[i]), 32'(GAP));
        end
        $display("replay level=%0d steps=%0d", lvl, vals.size());
    endtask

    // Called at a negedge in INPUT; returns at the negedge after release.
    task automatic press(input logic [NK-1:0] v, input int hold);
        key = v;
        @(negedge clk);
        check("echo", 32'(colour), 32'(v));
        check("release_input_phase", 32'(input_phase), 32'd1);
        for (int h = 1; h < hold; h++) begin
            key = NK'($urandom_range(1, (1 << NK) - 1));
            @(negedge clk);
            check("echo_hold", 32'(colour), 32'(v));
        end
        key = '0;
        @(negedge clk);
        rel_cyc = cyc;
        $display("press key=%b hold=%0d level=%0d over=%0d won=%0d", v, hold, level, game_over, game_won);
    endtask

    // Starts a game from IDLE/GAMEOVER/WIN; holds the start key and checks WAITREL.
    task automatic start_game(input int hold);
        key = NK'($urandom_range(1, (1 << NK) - 1));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("waitrel_quiet", {colour, 1'b0, game_over, game_won, input_phase}, 32'd0);
        end
        key = '0;
        @(negedge clk);
        append_cyc = cyc;
        check("start_append", 32'(dut.state_q), 32'(APPEND));
        model.delete();
        $display("start hold=%0d", hold);
    endtask

    // Plays one level; wrong_at<0 means every entry is correct.
    task automatic play_level(input int lvl, input int wrong_at, input bit multi);
        logic [NK-1:0] v;
        model.push_back(elem_at(append_cyc));
        watch_replay(lvl);
        for (int i = 0; i < lvl; i++) begin
            v = NK'(1) << model[i];
            if (i == wrong_at) begin
                if (multi) v = 4'b0011;
                else       v = NK'(1) << ((model[i] + int'($urandom_range(1, NK - 1))) % NK);
            end
            press(v, int'($urandom_range(1, 3)));
            if (i == wrong_at) begin
                check("wrong_game_over", 32'(game_over), 32'd1);
                check("wrong_level", 32'(level), 32'(lvl));
                check("wrong_colour", 32'(colour), 32'd0);
                return;
            end else if (i < lvl - 1) begin
                check("next_input", {30'd0, input_phase, game_over}, 32'b10);
            end else if (lvl == MAXL) begin
                check("win_flag", 32'(game_won), 32'd1);
                check("win_level", 32'(level), 32'(MAXL));
            end else begin
                check("pause_quiet", {29'd0, input_phase, game_over, game_won}, 32'd0);
                append_cyc = rel_cyc + GAP;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_flags", {29'd0, game_over, game_won, input_phase}, 32'd0);
        check("rst_lfsr", 32'(dut.u_lfsr.value), 32'hACE1);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_colour", 32'(colour), 32'd0);

        // Game 1: full win over MAXL levels.
        start_game(2);
        for (int l = 1; l <= MAXL; l++) play_level(l, -1, 0);
        repeat (5) @(negedge clk);
        check("win_held", {28'd0, colour}, 32'd0);
        check("win_level_held", 32'(level), 32'(MAXL));
        check("win_flag_held", 32'(game_won), 32'd1);

        // Game 2: wrong one-hot key at level 2.
        start_game(10);
        play_level(1, -1, 0);
        play_level(2, 1, 0);

        // Game 3: multi-key press at level 2.
        start_game(10);
        play_level(1, -1, 0);
        play_level(2, 0, 1);

        // Game 4: idle in INPUT.
        start_game(1);
        model.push_back(elem_at(append_cyc));
        watch_replay(1);
`ifdef COLOUR_GAME_TIMEOUT_EN
        repeat (TMO) @(negedge clk);
        check("timeout_before", {30'd0, input_phase, game_over}, 32'b10);
        @(negedge clk);
        check("timeout_game_over", 32'(game_over), 32'd1);
        check("timeout_level", 32'(level), 32'd1);
`else
        repeat (30) @(negedge clk);
        check("no_timeout", {30'd0, input_phase, game_over}, 32'b10);
`endif

        // Reset in the middle of a replay.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_game(1);
        for (int n = 0; n < 20 && colour == '0; n++) @(negedge clk);
        check("show_on_before_reset", 32'(dut.state_q), 32'(SHOW_ON));
        rst = 1'b1;
        #1;
        check("midrst_colour", 32'(colour), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_lfsr", 32'(dut.u_lfsr.value), 32'hACE1);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'(dut.state_q), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/colour_sequence_game.md
Name: colour_sequence_game

Overview:
- Parametrised Simon-style sequence game engine for the colour-memory display path.
- Each level appends one pseudo-random colour and replays the sequence as a one-hot colour code, so the pixel-colour mux is unchanged.
- It then checks the player's key presses and either advances the level, ends the game, or declares a win.
- Replaces the fixed 6-step hardcoded sequence with a generated, growing sequence of configurable length and key count.

Parameters:
- NUM_KEYS, 4, number of keys/colours; colour code is one-hot over this width (2..8).
- MAX_SEQ_LEN, 16, sequence length that wins the game (2..64).
- SHOW_CLOCKS, 12500000, cycles each colour is lit during replay (>=1).
- GAP_CLOCKS, 2500000, blank cycles after each replayed colour and after level completion (>=1).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.
- TIMEOUT_CLOCKS, 150000000, input timeout; used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key  in  NUM_KEYS  active-high key levels, already inverted and synchronised upstream
- colour  out  NUM_KEYS  one-hot colour to display; all-zero means black
- level  out  $clog2(MAX_SEQ_LEN+1)  current sequence length
- game_over  out  1  high while in GAMEOVER
- game_won  out  1  high while in WIN
- input_phase  out  1  high while waiting for player input (INPUT or RELEASE)

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state=IDLE, colour=0, level=0, game_over=0, game_won=0, input_phase=0
  - LFSR=LFSR_SEED; all counters=0
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle in every state.
  - New element = (LFSR[7:0]) mod NUM_KEYS, sampled in APPEND.
- Sequence storage: MAX_SEQ_LEN entries of $clog2(NUM_KEYS) bits; not cleared on reset.
- "Any key" means key != 0. "Valid press" means key is one-hot.
- States and transitions:
  - IDLE:
    - colour=0.
    - Any key -> WAITREL, with a flag set to go to APPEND next and level cleared to 0.
  - APPEND (1 cycle):
    - seq[level] <= element; level <= level+1; idx <= 0 -> SHOW_ON.
  - SHOW_ON:
    - colour=onehot(seq[idx]) for exactly SHOW_CLOCKS cycles -> SHOW_OFF.
  - SHOW_OFF:
    - colour=0 for GAP_CLOCKS cycles.
    - Then idx+1; if idx==level-1 -> INPUT with idx=0, otherwise -> SHOW_ON.
  - INPUT:
    - colour=0; keys pressed during replay are ignored.
    - On any key: colour <= key (echo).
    - If key==onehot(seq[idx]), mark correct, else mark wrong (includes multi-key presses).
    - -> RELEASE.
  - RELEASE:
    - colour holds the echoed key until key==0.
    - On release:
      - wrong -> GAMEOVER
      - correct and idx<level-1 -> idx+1, INPUT
      - correct and idx==level-1 and level==MAX_SEQ_LEN -> WIN
      - otherwise -> PAUSE
  - PAUSE:
    - colour=0 for GAP_CLOCKS cycles -> APPEND.
  - GAMEOVER / WIN:
    - Respective flag high, colour=0, level held for score display.
    - Any key -> WAITREL, with the flag set to go to APPEND and level cleared to 0.
  - WAITREL:
    - Waits for key==0 -> APPEND.
    - Prevents the start press being scored as the first input.
- Latency:
  - Key edge in INPUT to colour echo: 1 cycle.
  - Key release to next-state outputs: 1 cycle.
- Key input change mid-press: the decision is made on the first non-zero sample only.
- Reset mid-game: immediate return to IDLE; the stored sequence is irrelevant because level=0.
- Timers: single down-counter sized to max(SHOW_CLOCKS, GAP_CLOCKS, TIMEOUT_CLOCKS); loaded on state entry.

Optional Feature:
- Macro: COLOUR_GAME_TIMEOUT_EN.
- Defined:
  - In INPUT, the timer loads TIMEOUT_CLOCKS on entry.
  - If it expires with key==0 -> GAMEOVER.
  - The timer does not run in RELEASE.
- Undefined: INPUT waits indefinitely; TIMEOUT_CLOCKS is ignored.

Decomposition:
- Shared package colour_game_pkg:
  - state encoding constants (IDLE, APPEND, SHOW_ON, SHOW_OFF, INPUT, RELEASE, PAUSE, GAMEOVER, WIN, WAITREL)
  - colour-code-to-RGB565 constants (BLACK 16'h0000, GREEN 16'h5FE8, RED 16'hFA28, BLUE 16'h12DE, YELLOW 16'hFFC6)
- Sub-module: game_lfsr16 (parameter SEED; ports clock, reset, value[15:0]).

Test Plan:
- Reset mid-SHOW_ON with NUM_KEYS=4, SHOW=4, GAP=2, MAX=3 -> next cycle colour=0, level=0, state IDLE, LFSR=16'hACE1.
- Press key=4'b0001 then release from IDLE -> level=1; colour shows onehot(seq[0]) for exactly 4 cycles, then 0 for 2 cycles, then input_phase=1.
- Enter the bench-recorded replayed colours correctly for 3 levels (MAX=3) -> level steps 1,2,3; after the final release game_won=1 and level stays 3.
- At level 2, press the wrong one-hot key, or 4'b0011 -> colour echoes the pressed value; after release game_over=1 and level=2.
- In GAMEOVER, press then hold a key for 10 cycles -> stays in WAITREL with colour=0; release -> APPEND, level=1.
- With COLOUR_GAME_TIMEOUT_EN and TIMEOUT=8, no key in INPUT -> game_over=1 exactly 9 cycles after input_phase rises; without the macro it stays in INPUT.
